fsk_generator: RTL
==================

Name: fsk_generator

Overview:
- Transmit-side counterpart of the team's FSK frequency analyzer.
- Serialises parallel data words into a square wave. Each bit is sent for a fixed bit time: a 0 bit toggles at FREQUENCY0, a 1 bit toggles at FREQUENCY1.
- Output `sample_out` drives the analyzer's `sample_data` input, for loopback or on a line.
- Per-frequency tick accumulators mirror the analyzer's `f0_value`/`f1_value`, so results can be compared directly.

Parameters:
- FREQUENCY0, 9000: tone frequency for a 0 bit, in Hz.
- FREQUENCY1, 11000: tone frequency for a 1 bit, in Hz. Must be greater than FREQUENCY0.
- BIT_RATE, 1000: bits per second.
- DATA_WIDTH, 8: bits per frame.
- CLOCK_FREQUENCY, 50000000: clock frequency, in Hz.

Ports:
- clock, input, 1: the single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when 0, the block pauses (all state frozen).
- data_in, input, DATA_WIDTH: word to transmit, LSB first.
- data_valid, input, 1: `data_in` is valid.
- data_ready, output, 1: block can accept a word.
- sample_out, output, 1: FSK square-wave output.
- busy, output, 1: a frame is in progress.
- tx_done, output, 1: one-cycle pulse when a frame completes.
- f0_value, output, 32: clock cycles spent emitting FREQUENCY0.
- f1_value, output, 32: clock cycles spent emitting FREQUENCY1.

Behaviour:
- Derived constants (integer division, truncating):
  - T0 = CLOCK_FREQUENCY/(2*FREQUENCY0)
  - T1 = CLOCK_FREQUENCY/(2*FREQUENCY1)
  - TB = CLOCK_FREQUENCY/BIT_RATE
  - Constraints: T0, T1 >= 2 and TB >= T0.
- Reset, when asserted at a clock edge:
  - state = IDLE; sample_out, busy, tx_done = 0.
  - f0_value, f1_value = 0; shift register, half_cnt, bit_cnt, bit_idx = 0.
  - data_ready = 0 while reset is high.
  - Reset overrides every other input, including in the middle of a frame (the frame is aborted and not resumed).
- data_ready = (state==IDLE) && enable && !reset. This is combinational from the state register.
- States:
  - IDLE:
    - sample_out holds its current level.
    - On an edge with data_valid && data_ready: latch data_in into the shift register; half_cnt, bit_cnt, bit_idx = 0; go to SEND.
  - SEND, with enable=1, on each edge:
    - Current tone is T = shreg[0] ? T1 : T0.
    - Increment f1_value if shreg[0] is 1, otherwise f0_value. Both saturate at 0xFFFFFFFF.
    - If half_cnt == T-1: toggle sample_out and set half_cnt = 0. Otherwise half_cnt++.
    - If bit_cnt == TB-1: bit_cnt = 0; half_cnt = 0 (this overrides the line above; a toggle due on the same edge still happens); shift the register right; bit_idx++.
    - If that bit end is on bit DATA_WIDTH-1: go to IDLE and pulse tx_done for the next cycle. Otherwise bit_cnt++ as usual.
  - SEND with enable=0: everything frozen, no counting, sample_out held.
- Phase: sample_out is continuous across bits and frames (no forced level at bit boundaries). The half-period restarts at each bit boundary.
- Timing:
  - Frame latency: tx_done goes high in the cycle after DATA_WIDTH*TB enabled SEND cycles.
  - busy = (state==SEND).
  - Minimum one IDLE cycle between frames: data_ready rises in the cycle tx_done is high.
- data_valid while not ready: ignored; the word is not latched.
- data_in changes during SEND: no effect.
- f0_value and f1_value are not cleared between frames, only by reset.

Test Plan (overrides: CLOCK_FREQUENCY=1000, FREQUENCY0=50, FREQUENCY1=100, BIT_RATE=10, DATA_WIDTH=8, giving T0=10, T1=5, TB=100):
- Reset: hold reset 3 cycles with enable=1 → all outputs 0, data_ready=0 during reset, data_ready=1 on the first cycle after.
- Send 0x00 → sample_out toggles every 10 cycles (80 toggles), final level 0. tx_done pulses exactly once, 800 cycles after acceptance. f0_value=800, f1_value=0.
- Send 0xFF after reset → toggles every 5 cycles (160 toggles). f1_value=800, f0_value=0.
- Send 0x01 after reset → first 100 cycles toggle every 5 (20 toggles), then toggle every 10 (70 toggles). f1_value=100, f0_value=700.
- Send 0x00 and drop enable for 37 cycles at cycle 123 → sample_out and counters frozen during the gap. tx_done arrives 837 cycles after acceptance; f0_value=800.
- Assert reset at SEND cycle 250 while data_valid=1 → next cycle: state IDLE, sample_out=0, f0_value=0, no tx_done. The word presented during reset is not accepted. After reset, a new 0x55 is accepted and completes normally.

Source files
------------

// File: rtl/fsk_generator.sv
// fsk_generator: serialises words LSB first into an FSK square wave with per-tone cycle accumulators
module fsk_generator #(
  parameter int FREQUENCY0      = 9000,
  parameter int FREQUENCY1      = 11000,
  parameter int BIT_RATE        = 1000,
  parameter int DATA_WIDTH      = 8,
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sample_out,
  output logic                  busy,
  output logic                  tx_done,
  output logic [31:0]           f0_value,
  output logic [31:0]           f1_value
);
  localparam logic [31:0] T0 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY0));
  localparam logic [31:0] T1 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY1));
  localparam logic [31:0] TB = 32'(CLOCK_FREQUENCY / BIT_RATE);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [31:0] half_q, half_d, bit_q, bit_d, f0_q, f0_d, f1_q, f1_d, tone;
  logic [IW-1:0] idx_q, idx_d;
  logic sample_q, sample_d, done_q, done_d, flip;
  assign data_ready = (state_q == IDLE) && enable && !reset;
  assign busy       = (state_q == SEND);
  assign sample_out = sample_q;
  assign tx_done    = done_q;
  assign f0_value   = f0_q;
  assign f1_value   = f1_q;
  assign tone       = shreg_q[0] ? T1 : T0;
  assign flip       = (half_q == tone - 32'd1);
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    half_d   = half_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    done_d   = 1'b0;
    if (state_q == IDLE && data_valid && data_ready) begin
      state_d = SEND;
      shreg_d = data_in;
      half_d  = '0;
      bit_d   = '0;
      idx_d   = '0;
    end else if (state_q == SEND && enable) begin
      f0_d     = (!shreg_q[0] && f0_q != '1) ? f0_q + 32'd1 : f0_q;
      f1_d     = (shreg_q[0] && f1_q != '1) ? f1_q + 32'd1 : f1_q;
      sample_d = flip ? ~sample_q : sample_q;
      half_d   = flip ? '0 : half_q + 32'd1;
      // the half-period restarts at every bit boundary, but a toggle due on that edge still fires
      if (bit_q == TB - 32'd1) begin
        bit_d   = '0;
        half_d  = '0;
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == LAST) ? IDLE : SEND;
        done_d  = (idx_q == LAST);
      end else begin
        bit_d = bit_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      f0_q     <= '0;
      f1_q     <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
    end
  end
endmodule
